score_time_dabbler: RTL and testbench
=====================================

SCORE_TIME_DABBLER -- requirements
Module: score_time_dabbler

Interface
REQ-001 The block SHALL have parameter AUTO, default 0: 0 = convert only on start; 1 = restart automatically from IDLE, start ignored.
REQ-002 The block SHALL have port clk, input, 1, the single FPGA clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, conversion request, sampled only in IDLE.
REQ-005 The block SHALL have port score, input, 14, unsigned binary game score from the data holder.
REQ-006 The block SHALL have port g_time, input, 9, unsigned binary game time from the data holder.
REQ-007 The block SHALL have port score_bcd, output, 20, five BCD digits; [19:16] is ten-thousands.
REQ-008 The block SHALL have port time_bcd, output, 12, three BCD digits; [11:8] is hundreds.
REQ-009 The block SHALL have port busy, output, 1, high while in SHIFT.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse; BCD outputs updated in that same cycle.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-012 The block SHALL move IDLE->SHIFT on the edge where start=1 (AUTO=0), or on every IDLE cycle (AUTO=1).
REQ-013 The block SHALL capture score and g_time (zero-extended to 14 bits) into internal shift registers on the IDLE->SHIFT edge; later input changes SHALL NOT affect that conversion.
REQ-014 The block SHALL clear both internal BCD accumulators on the IDLE->SHIFT edge.
REQ-015 The block SHALL stay in SHIFT exactly 14 cycles, counted by a 4-bit counter from 0 to 13.
REQ-016 In each SHIFT cycle, each accumulator digit >= 5 SHALL first be increased by 3, then the accumulator SHALL shift left 1 bit, taking the binary register MSB in.
REQ-017 Score and time SHALL be converted in parallel with one shared counter.
REQ-018 The time accumulator SHALL be 12 bits; the 5 leading zero bits from zero-extension SHALL shift through without changing the result.
REQ-019 The block SHALL go SHIFT->DONE after counter 13, loading score_bcd and time_bcd from the accumulators on that edge.
REQ-020 The block SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE.
REQ-021 Latency: start high in cycle T SHALL give busy high in T+1..T+14, and done plus new outputs in T+15.
REQ-022 With AUTO=1, done SHALL repeat every 16 cycles.
REQ-023 start in SHIFT or DONE SHALL be ignored; it is neither queued nor restarts the conversion.
REQ-024 score_bcd and time_bcd SHALL hold their last values between done pulses.
REQ-025 Full input range SHALL convert exactly with no clamping: score 0..16383, g_time 0..511.
REQ-026 busy and done SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 SHALL force IDLE, counter=0, busy=0, done=0, score_bcd=0, time_bcd=0 and all shift registers and accumulators to 0 on the next edge.
REQ-028 rst SHALL take priority over start and over all FSM activity, including in SHIFT or DONE.
REQ-029 A conversion interrupted by rst SHALL be discarded: no done pulse and no output update.
REQ-030 With AUTO=1, the first conversion SHALL start on the first IDLE cycle after rst deasserts.

Verification
REQ-031 The bench SHALL cover: score=16383, g_time=500, start pulse at T -> busy T+1..T+14; done at T+15; score_bcd=20'h16383, time_bcd=12'h500.
REQ-032 The bench SHALL cover: score=0, g_time=0 -> score_bcd=0, time_bcd=0 at done; then score=9999, g_time=511 -> 20'h09999, 12'h511.
REQ-033 The bench SHALL cover: start at T, score changed to 1234 at T+3, start re-pulsed at T+5 -> one done at T+15 holding the T-captured value; no second done.
REQ-034 The bench SHALL cover: rst asserted at T+7 of a conversion -> busy=0, outputs 0, no done; then start with score=4321, g_time=99 -> 20'h04321, 12'h099 after 15 cycles.
REQ-035 The bench SHALL cover: AUTO=1, score stepped 10, 20, 30 -> done every 16 cycles; each result equals the score captured at its IDLE->SHIFT edge.
REQ-036 The bench SHALL cover: random score/g_time, 1000 conversions vs. a decimal reference model -> all match; busy and done never high together.

Source files
------------

// File: rtl/score_time_dabbler.sv
// Converts a 14-bit game score and a 9-bit game time to BCD with a shared
// 14-step shift-and-add-3 sequencer; results are published with a one-cycle done pulse.
module score_time_dabbler #(
  parameter bit AUTO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] score,
  input  logic [8:0]  g_time,
  output logic [19:0] score_bcd,
  output logic [11:0] time_bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [13:0] score_bin_q;
  logic [13:0] time_bin_q;
  logic [19:0] score_acc_q;
  logic [11:0] time_acc_q;
  logic [19:0] score_bcd_q;
  logic [11:0] time_bcd_q;
  logic        busy_q;
  logic        done_q;

  logic [19:0] score_adj;
  logic [11:0] time_adj;
  logic [19:0] score_shift_d;
  logic [11:0] time_shift_d;
  logic        score_adj_msb_unused;
  logic        time_adj_msb_unused;

  // Add-3 correction per BCD digit, applied before each shift
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_score_adj
      assign score_adj[gi*4 +: 4] = (score_acc_q[gi*4 +: 4] >= 4'd5) ?
                                    score_acc_q[gi*4 +: 4] + 4'd3 :
                                    score_acc_q[gi*4 +: 4];
    end
    for (gi = 0; gi < 3; gi++) begin : g_time_adj
      assign time_adj[gi*4 +: 4] = (time_acc_q[gi*4 +: 4] >= 4'd5) ?
                                   time_acc_q[gi*4 +: 4] + 4'd3 :
                                   time_acc_q[gi*4 +: 4];
    end
  endgenerate

  // The accumulator MSB falls off the top; it is always zero for in-range inputs
  assign {score_adj_msb_unused, score_shift_d} = {score_adj, score_bin_q[13]};
  assign {time_adj_msb_unused, time_shift_d}   = {time_adj, time_bin_q[13]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      score_bin_q <= 14'd0;
      time_bin_q  <= 14'd0;
      score_acc_q <= 20'd0;
      time_acc_q  <= 12'd0;
      score_bcd_q <= 20'd0;
      time_bcd_q  <= 12'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (AUTO || start) begin
            state_q     <= SHIFT;
            busy_q      <= 1'b1;
            cnt_q       <= 4'd0;
            score_bin_q <= score;
            time_bin_q  <= {5'd0, g_time};
            score_acc_q <= 20'd0;
            time_acc_q  <= 12'd0;
          end
        end
        SHIFT: begin
          score_acc_q <= score_shift_d;
          time_acc_q  <= time_shift_d;
          score_bin_q <= {score_bin_q[12:0], 1'b0};
          time_bin_q  <= {time_bin_q[12:0], 1'b0};
          cnt_q       <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cnt_q       <= 4'd0;
            score_bcd_q <= score_shift_d;
            time_bcd_q  <= time_shift_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign score_bcd = score_bcd_q;
  assign time_bcd  = time_bcd_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_score_time_dabbler.sv
// Bench for score_time_dabbler: table vectors, hand-written corner sequences,
// an AUTO=1 instance and random conversions checked against a decimal model.
module tb_score_time_dabbler;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [13:0] score;
  logic [8:0]  g_time;
  logic [19:0] score_bcd;
  logic [11:0] time_bcd;
  logic        busy, done;

  logic        a_rst, a_start;
  logic [13:0] a_score;
  logic [8:0]  a_g_time;
  logic [19:0] a_score_bcd;
  logic [11:0] a_time_bcd;
  logic        a_busy, a_done;

  int total = 0;
  int bad   = 0;

  logic [19:0] sb_s[$];
  logic [11:0] sb_t[$];
  logic [19:0] asb_s[$];
  logic [11:0] asb_t[$];

  typedef struct {
    int          s;
    int          g;
    logic [19:0] es;
    logic [11:0] et;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  score_time_dabbler #(.AUTO(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .score(score), .g_time(g_time),
    .score_bcd(score_bcd), .time_bcd(time_bcd), .busy(busy), .done(done)
  );

  score_time_dabbler #(.AUTO(1'b1)) dut_auto (
    .clk(clk), .rst(a_rst), .start(a_start), .score(a_score), .g_time(a_g_time),
    .score_bcd(a_score_bcd), .time_bcd(a_time_bcd), .busy(a_busy), .done(a_done)
  );

  function automatic logic [19:0] to_bcd(input int v, input int nd);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: pop expected results whenever a done pulse appears
  always @(negedge clk) begin
    total++;
    if (busy && done) begin
      bad++;
      $display("FAIL busy_done_overlap: busy=1 done=1 expected not both");
    end
    if (done) begin
      if (sb_s.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: score_bcd=%h with empty scoreboard", score_bcd);
      end else begin
        logic [19:0] es;
        logic [11:0] et;
        es = sb_s.pop_front();
        et = sb_t.pop_front();
        check("score_bcd", 32'(score_bcd), 32'(es));
        check("time_bcd", 32'(time_bcd), 32'(et));
        $display("conv: score_bcd=%h time_bcd=%h (exp %h %h)", score_bcd, time_bcd, es, et);
      end
    end
  end

  always @(negedge clk) begin
    if (a_busy && a_done) begin
      total++;
      bad++;
      $display("FAIL auto_busy_done_overlap: both high");
    end
    if (a_done) begin
      if (asb_s.size() == 0) begin
        total++;
        bad++;
        $display("FAIL auto_unexpected_done: score_bcd=%h", a_score_bcd);
      end else begin
        logic [19:0] es;
        logic [11:0] et;
        es = asb_s.pop_front();
        et = asb_t.pop_front();
        check("auto_score_bcd", 32'(a_score_bcd), 32'(es));
        check("auto_time_bcd", 32'(a_time_bcd), 32'(et));
        $display("auto conv: score_bcd=%h time_bcd=%h (exp %h %h)", a_score_bcd, a_time_bcd, es, et);
      end
    end
  end

  // One conversion started in cycle 0; optional input change, start re-pulse and reset
  task automatic run_conv(input int s, input int g, input logic [19:0] es, input logic [11:0] et,
                          input int ncyc, input int change_at, input int change_val,
                          input int repulse_at, input int rst_at);
    logic [63:0] busy_seen, done_seen, busy_exp, done_exp;
    busy_seen = '0;
    done_seen = '0;
    busy_exp  = '0;
    done_exp  = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == repulse_at);
      rst   = (c == rst_at);
      if (c == 0) begin
        score  = 14'(s);
        g_time = 9'(g);
        sb_s.push_back(es);
        sb_t.push_back(et);
      end
      if (c == change_at) score = 14'(change_val);
      if (c == rst_at) begin
        sb_s.delete();
        sb_t.delete();
      end
      @(negedge clk);
      busy_seen[c] = busy;
      done_seen[c] = done;
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_score_zero", 32'(score_bcd), 32'd0);
        check("rst_time_zero", 32'(time_bcd), 32'd0);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      busy_exp[c] = (c >= 1) && (c <= 14) && (rst_at < 0 || c <= rst_at);
      done_exp[c] = (c == 15) && (rst_at < 0);
    end
    check("busy_window", busy_seen[31:0], busy_exp[31:0]);
    check("done_window", done_seen[31:0], done_exp[31:0]);
    check("sb_drained", 32'(sb_s.size()), 32'd0);
    if (rst_at < 0) begin
      check("hold_score", 32'(score_bcd), 32'(es));
      check("hold_time", 32'(time_bcd), 32'(et));
    end
  endtask

  initial begin
    logic [63:0] adone_seen, adone_exp;
    rst = 1'b1; start = 1'b0; score = '0; g_time = '0;
    a_rst = 1'b1; a_start = 1'b0; a_score = '0; a_g_time = '0;

    vecs[0] = '{16383, 500, 20'h16383, 12'h500};
    vecs[1] = '{0,     0,   20'h00000, 12'h000};
    vecs[2] = '{9999,  511, 20'h09999, 12'h511};
    vecs[3] = '{10000, 1,   20'h10000, 12'h001};
    vecs[4] = '{8191,  256, 20'h08191, 12'h256};
    vecs[5] = '{5,     59,  20'h00005, 12'h059};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_score", 32'(score_bcd), 32'd0);
    check("reset_time", 32'(time_bcd), 32'd0);

    for (int i = 0; i < 6; i++)
      run_conv(vecs[i].s, vecs[i].g, vecs[i].es, vecs[i].et, 17, -1, 0, -1, -1);

    // Input change at T+3 and start re-pulse at T+5 must not disturb the conversion
    run_conv(5678, 42, 20'h05678, 12'h042, 36, 3, 1234, 5, -1);

    // Reset in the middle of a conversion discards it; then a clean conversion
    run_conv(9999, 511, 20'h09999, 12'h511, 17, -1, 0, -1, -1);
    run_conv(7777, 300, 20'h07777, 12'h300, 20, -1, 0, -1, 7);
    run_conv(4321, 99, 20'h04321, 12'h099, 17, -1, 0, -1, -1);

    // AUTO=1: conversions start on every IDLE cycle after reset releases
    adone_seen = '0;
    adone_exp  = '0;
    a_score  = 14'd10;
    a_g_time = 9'd7;
    for (int c = 0; c < 48; c++) begin
      @(posedge clk);
      #1;
      a_rst   = 1'b0;
      a_start = c[0];
      if (c == 8)  a_score = 14'd20;
      if (c == 24) a_score = 14'd30;
      if (c == 0)  begin asb_s.push_back(20'h00010); asb_t.push_back(12'h007); end
      if (c == 16) begin asb_s.push_back(20'h00020); asb_t.push_back(12'h007); end
      if (c == 32) begin asb_s.push_back(20'h00030); asb_t.push_back(12'h007); end
      @(negedge clk);
      adone_seen[c] = a_done;
      adone_exp[c]  = (c == 15) || (c == 31) || (c == 47);
    end
    @(posedge clk);
    #1 a_rst = 1'b1; a_start = 1'b0;
    check("auto_done_lo", adone_seen[31:0], adone_exp[31:0]);
    check("auto_done_hi", 32'(adone_seen[47:32]), 32'(adone_exp[47:32]));
    check("auto_sb_drained", 32'(asb_s.size()), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      int s, g;
      s = int'($urandom_range(16383, 0));
      g = int'($urandom_range(511, 0));
      run_conv(s, g, to_bcd(s, 5), to_bcd(g, 3) & 20'hfff, 17, -1, 0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
